// File: rtl/hilo_mul_sequencer.sv
// HI/LO multiply sequencer: iterative shift-add multiplier that owns the HI and LO registers.
// Executes MULT/MULTU/MADD/MSUB/MTHI/MTLO, serves MFHI/MFLO and stalls colliding HI/LO ops.
module hilo_mul_sequencer #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             op_valid_i,
    input  logic [5:0]       alu_control_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] read_data_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [5:0] OpMult  = 6'd4;
    localparam logic [5:0] OpMultu = 6'd5;
    localparam logic [5:0] OpMadd  = 6'd6;
    localparam logic [5:0] OpMsub  = 6'd7;
    localparam logic [5:0] OpMthi  = 6'd32;
    localparam logic [5:0] OpMtlo  = 6'd33;
    localparam logic [5:0] OpMfhi  = 6'd34;
    localparam logic [5:0] OpMflo  = 6'd35;

    typedef enum logic [1:0] {StIdle, StMul, StAcc} state_e;
    typedef enum logic [1:0] {KindMul, KindMadd, KindMsub} kind_e;

    state_e               state_q, state_d;
    kind_e                kind_q, kind_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_mul_op;
    logic                 is_hilo_op;
    logic                 start;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   step_sum;
    logic [2*WIDTH-1:0]   prod;

    // Opcode decode, stall and operand magnitudes for the start of a multiply.
    always_comb begin
        is_mul_op  = (alu_control_i >= OpMult) && (alu_control_i <= OpMsub);
        is_hilo_op = is_mul_op || ((alu_control_i >= OpMthi) && (alu_control_i <= OpMflo));
        busy_o     = (state_q != StIdle);
        stall_o    = busy_o && op_valid_i && is_hilo_op;
        start      = (state_q == StIdle) && op_valid_i && is_mul_op && !flush_i;
        // MULTU treats operands as raw unsigned values; the rest work on magnitudes.
        a_neg      = (alu_control_i != OpMultu) && a_i[WIDTH-1];
        b_neg      = (alu_control_i != OpMultu) && b_i[WIDTH-1];
        a_mag      = a_neg ? -a_i : a_i;
        b_mag      = b_neg ? -b_i : b_i;
    end

    // One iteration: add the shifted multiplicand for each set multiplier bit in this slice.
    always_comb begin
        step_sum = acc_q;
        for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
            if (mplier_q[k]) begin
                step_sum = step_sum + (mcand_q << k);
            end
        end
        prod = neg_q ? -acc_q : acc_q;
    end

    // Next-state logic for the FSM, multiplier datapath and HI/LO.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    neg_d    = a_neg ^ b_neg;
                    cnt_d    = CntW'(N - 1);
                    state_d  = StMul;
                    if (alu_control_i == OpMadd) begin
                        kind_d = KindMadd;
                    end else if (alu_control_i == OpMsub) begin
                        kind_d = KindMsub;
                    end else begin
                        kind_d = KindMul;
                    end
                end else if (op_valid_i && (alu_control_i == OpMthi)) begin
                    hi_d = a_i;
                end else if (op_valid_i && (alu_control_i == OpMtlo)) begin
                    lo_d = a_i;
                end
            end
            StMul: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                if (cnt_q == '0) begin
                    state_d = StAcc;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAcc: begin
                unique case (kind_q)
                    KindMadd: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    KindMsub: {hi_d, lo_d} = {hi_q, lo_q} - prod;
                    default:  {hi_d, lo_d} = prod;
                endcase
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A kill abandons the multiply without touching HI/LO or raising Done.
        if (flush_i && (state_q != StIdle)) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            kind_q   <= KindMul;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // MFHI/MFLO read port and architectural outputs.
    always_comb begin
        read_data_o = '0;
        if (alu_control_i == OpMfhi) begin
            read_data_o = hi_q;
        end else if (alu_control_i == OpMflo) begin
            read_data_o = lo_q;
        end
        hi_o   = hi_q;
        lo_o   = lo_q;
        done_o = done_q;
    end

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Self-checking bench for hilo_mul_sequencer: directed vectors plus randomized ops against a
// 64-bit arithmetic model of the HI/LO pair.
module tb_hilo_mul_sequencer;

    localparam logic [5:0] OP_MULT  = 6'd4;
    localparam logic [5:0] OP_MULTU = 6'd5;
    localparam logic [5:0] OP_MADD  = 6'd6;
    localparam logic [5:0] OP_MSUB  = 6'd7;
    localparam logic [5:0] OP_MTHI  = 6'd32;
    localparam logic [5:0] OP_MTLO  = 6'd33;
    localparam logic [5:0] OP_MFHI  = 6'd34;
    localparam logic [5:0] OP_MFLO  = 6'd35;
    localparam logic [5:0] OP_ADD   = 6'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  alu;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] rd, hi, lo;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] m_hl;

    always #5 clk = ~clk;

    hilo_mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .op_valid_i   (op_valid),
        .alu_control_i(alu),
        .a_i          (a),
        .b_i          (b),
        .flush_i      (flush),
        .busy_o       (busy),
        .stall_o      (stall),
        .done_o       (done),
        .read_data_o  (rd),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    function automatic logic [63:0] ref_prod(logic [5:0] op, logic [31:0] x, logic [31:0] y);
        longint sx, sy;
        logic [63:0] ux, uy;
        if (op == OP_MULTU) begin
            ux = {32'b0, x};
            uy = {32'b0, y};
            return ux * uy;
        end
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    function automatic void model_apply(logic [5:0] op, logic [31:0] x, logic [31:0] y);
        case (op)
            OP_MULT, OP_MULTU: m_hl = ref_prod(op, x, y);
            OP_MADD:           m_hl = m_hl + ref_prod(op, x, y);
            OP_MSUB:           m_hl = m_hl - ref_prod(op, x, y);
            OP_MTHI:           m_hl[63:32] = x;
            OP_MTLO:           m_hl[31:0] = x;
            default:           ;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issues a multiply, waits (bounded) for Busy to drop and updates the model.
    task automatic run_mul(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                           output int busy_cycles, output bit done_seen);
        op_valid = 1'b1; alu = op; a = x; b = y;
        @(posedge clk); #1;
        op_valid = 1'b0; alu = OP_ADD;
        busy_cycles = 0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
        done_seen = done;
        model_apply(op, x, y);
    endtask

    task automatic do_mt(input logic [5:0] op, input logic [31:0] x);
        op_valid = 1'b1; alu = op; a = x;
        @(posedge clk); #1;
        op_valid = 1'b0; alu = OP_ADD;
        model_apply(op, x, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b0; alu = OP_ADD; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, stall, hi, lo, rd} !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b stall=%b hi=%h lo=%h, want all 0",
                     busy, done, stall, hi, lo);
        end
        rst_n = 1'b1;
        m_hl = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int bc; bit ds;
        logic [31:0] exp_hi [6];
        logic [31:0] exp_lo [6];
        // Spec vectors 1, 2 (x2), 3 (x2), 4 (x2) with MT ops interleaved.
        run_mul(OP_MULT, 32'hFFFF_FFFF, 32'h2, bc, ds);
        checks++;
        if (bc != 33 || !ds) begin
            failures++;
            $display("FAIL mult_latency: got busy_cycles=%0d done=%b, want 33 and 1", bc, ds);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL mult_neg: got %h_%h, want ffffffff_fffffffe", hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: got done=%b one cycle later, want 0", done);
        end
        exp_hi = '{32'h1, 32'hFFFF_FFFE, 32'h5, 32'h5, 32'hFFFF_FFFF, 32'h4000_0000};
        exp_lo = '{32'hFFFF_FFFE, 32'h1, 32'h13, 32'h0, 32'hFFFF_FFFF, 32'h0};
        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'h2, bc, ds);
        checks++;
        if (hi !== exp_hi[0] || lo !== exp_lo[0]) begin
            failures++;
            $display("FAIL multu_small: got %h_%h, want %h_%h", hi, lo, exp_hi[0], exp_lo[0]);
        end
        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, ds);
        checks++;
        if (hi !== exp_hi[1] || lo !== exp_lo[1]) begin
            failures++;
            $display("FAIL multu_max: got %h_%h, want %h_%h", hi, lo, exp_hi[1], exp_lo[1]);
        end
        do_mt(OP_MTHI, 32'h5);
        checks++;
        if (busy !== 1'b0 || hi !== 32'h5) begin
            failures++;
            $display("FAIL mthi: got busy=%b hi=%h, want 0 and 00000005", busy, hi);
        end
        do_mt(OP_MTLO, 32'h7);
        checks++;
        if (busy !== 1'b0 || lo !== 32'h7) begin
            failures++;
            $display("FAIL mtlo: got busy=%b lo=%h, want 0 and 00000007", busy, lo);
        end
        run_mul(OP_MADD, 32'h3, 32'h4, bc, ds);
        checks++;
        if (hi !== exp_hi[2] || lo !== exp_lo[2]) begin
            failures++;
            $display("FAIL madd: got %h_%h, want %h_%h", hi, lo, exp_hi[2], exp_lo[2]);
        end
        run_mul(OP_MSUB, 32'h1, 32'h13, bc, ds);
        checks++;
        if (hi !== exp_hi[3] || lo !== exp_lo[3]) begin
            failures++;
            $display("FAIL msub: got %h_%h, want %h_%h", hi, lo, exp_hi[3], exp_lo[3]);
        end
        do_mt(OP_MTHI, 32'h0);
        do_mt(OP_MTLO, 32'h0);
        run_mul(OP_MSUB, 32'h1, 32'h1, bc, ds);
        checks++;
        if (hi !== exp_hi[4] || lo !== exp_lo[4]) begin
            failures++;
            $display("FAIL msub_wrap: got %h_%h, want %h_%h", hi, lo, exp_hi[4], exp_lo[4]);
        end
        run_mul(OP_MULT, 32'h8000_0000, 32'h8000_0000, bc, ds);
        checks++;
        if (hi !== exp_hi[5] || lo !== exp_lo[5]) begin
            failures++;
            $display("FAIL mult_minint: got %h_%h, want %h_%h", hi, lo, exp_hi[5], exp_lo[5]);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [5:0] op;
        logic [31:0] x, y;
        int bc; bit ds;
        ops = '{OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO};
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 5)];
            x  = pick_operand();
            y  = pick_operand();
            if (op == OP_MTHI || op == OP_MTLO) begin
                do_mt(op, x);
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_mt_busy[%0d]: got busy=%b, want 0", i, busy);
                end
            end else begin
                run_mul(op, x, y, bc, ds);
                checks++;
                if (bc != 33 || !ds) begin
                    failures++;
                    $display("FAIL rand_latency[%0d]: got busy_cycles=%0d done=%b, want 33/1",
                             i, bc, ds);
                end
            end
            checks++;
            if ({hi, lo} !== m_hl) begin
                failures++;
                $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h_%h, want %h",
                         i, op, x, y, hi, lo, m_hl);
            end
            op_valid = 1'b1;
            alu = (i % 2 == 0) ? OP_MFHI : OP_MFLO;
            #1;
            checks++;
            if (stall !== 1'b0 || rd !== ((i % 2 == 0) ? m_hl[63:32] : m_hl[31:0])) begin
                failures++;
                $display("FAIL rand_read[%0d]: got stall=%b rd=%h, want 0 and model value",
                         i, stall, rd);
            end
            op_valid = 1'b0;
            alu = OP_ADD;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [31:0] x, y;
        int stall_cycles;
        x = $urandom; y = $urandom;
        op_valid = 1'b1; alu = OP_MULT; a = x; b = y;
        @(posedge clk); #1;
        alu = OP_ADD;
        #1;
        checks++;
        if (busy !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL add_no_stall: got busy=%b stall=%b, want 1 and 0", busy, stall);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        alu = OP_MFLO;
        model_apply(OP_MULT, x, y);
        stall_cycles = 0;
        #1;
        while (stall && stall_cycles < 200) begin
            stall_cycles++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles != 31) begin
            failures++;
            $display("FAIL mflo_stall_len: got %0d stalled cycles, want 31", stall_cycles);
        end
        checks++;
        if (done !== 1'b1 || rd !== m_hl[31:0]) begin
            failures++;
            $display("FAIL mflo_after_stall: got done=%b rd=%h, want 1 and %h",
                     done, rd, m_hl[31:0]);
        end
        op_valid = 1'b0;
        alu = OP_ADD;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int done_hits;
        logic [31:0] x;
        op_valid = 1'b1; alu = OP_MULT; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        op_valid = 1'b0; alu = OP_ADD;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_abort: got busy=%b done=%b, want 0 and 0", busy, done);
        end
        done_hits = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_hits++;
        end
        checks++;
        if (done_hits != 0 || {hi, lo} !== m_hl) begin
            failures++;
            $display("FAIL flush_no_update: got done_hits=%0d hilo=%h_%h, want 0 and %h",
                     done_hits, hi, lo, m_hl);
        end
        op_valid = 1'b1; alu = OP_MADD; a = 32'h3; b = 32'h3; flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; alu = OP_ADD; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_blocks_start: got busy=%b, want 0", busy);
        end
        x = $urandom;
        flush = 1'b1;
        do_mt(OP_MTHI, x);
        flush = 1'b0;
        checks++;
        if (hi !== x || {hi, lo} !== m_hl) begin
            failures++;
            $display("FAIL flush_idle_mthi: got hi=%h, want %h", hi, x);
        end
    endtask

    task automatic test_back_to_back();
        int bc; bit ds;
        logic [31:0] x, y;
        run_mul(OP_MULT, $urandom, $urandom, bc, ds);
        checks++;
        if (!ds || {hi, lo} !== m_hl) begin
            failures++;
            $display("FAIL b2b_first: got done=%b hilo=%h_%h, want 1 and %h", ds, hi, lo, m_hl);
        end
        x = pick_operand(); y = pick_operand();
        run_mul(OP_MSUB, x, y, bc, ds);
        checks++;
        if (bc != 33 || !ds || {hi, lo} !== m_hl) begin
            failures++;
            $display("FAIL b2b_second: got busy_cycles=%0d done=%b hilo=%h_%h, want 33/1/%h",
                     bc, ds, hi, lo, m_hl);
        end
    endtask

    task automatic test_reset_midop();
        int bc; bit ds;
        op_valid = 1'b1; alu = OP_MADD; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        alu = OP_MFHI;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, stall, hi, lo, rd} !== '0) begin
            failures++;
            $display("FAIL reset_midop: got busy=%b done=%b stall=%b hi=%h lo=%h rd=%h, want 0",
                     busy, done, stall, hi, lo, rd);
        end
        op_valid = 1'b0; alu = OP_ADD;
        m_hl = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_mul(OP_MADD, 32'hFFFF_FFFD, 32'h7, bc, ds);
        checks++;
        if (bc != 33 || {hi, lo} !== m_hl) begin
            failures++;
            $display("FAIL after_reset_madd: got busy_cycles=%0d hilo=%h_%h, want 33 and %h",
                     bc, hi, lo, m_hl);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
